// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-wide memory bus sequencer.
package mem_ctrl_pkg;

  localparam int         ADDR_W_DEFAULT = 32;
  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  // Access length encoding on mem_len
  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } state_t;

  // Number of bus byte cycles for an access length (11 behaves as a word)
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  // Byte lane idx of a little-endian word
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the IF/MEM pipeline stages and mem_ctrl.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);
  // instruction fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_abort;
  logic              if_done;
  logic [31:0]       if_inst;
  // load/store port
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  // stall requests towards the pipeline stall controller
  logic              stall_req_if;
  logic              stall_req_mem;

  modport master (
    output if_req, if_addr, if_abort, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  if_done, if_inst, mem_done, mem_rdata, stall_req_if, stall_req_mem
  );

  modport slave (
    input  if_req, if_addr, if_abort, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output if_done, if_inst, mem_done, mem_rdata, stall_req_if, stall_req_mem
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbiter/sequencer for the shared single-port byte-wide RAM/IO bus.
// MEM has priority over IF; each access is split into byte cycles and
// read bytes are assembled little-endian into a 32-bit result.
// ram_din is sampled on the edge after the address is driven.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT,
  parameter int         ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              io_buffer_full,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  mem_ctrl_if.slave         bus
);

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [2:0]        nbytes_reg, nbytes_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        dout_reg, dout_next;
  logic              wr_reg, wr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       buf_reg, buf_next;
  logic [31:0]       if_inst_reg, if_inst_next;
  logic [31:0]       mem_rdata_reg, mem_rdata_next;
  logic              if_done_reg, if_done_next;
  logic              mem_done_reg, mem_done_next;

  logic [2:0]        cnt_inc;
  logic              last_byte;
  logic              io_block;
  logic              grant_ok;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       cap_word;
  logic              if_done_out;
  logic              mem_done_out;

  assign cnt_inc   = cnt_reg + 3'd1;
  assign last_byte = (cnt_inc == nbytes_reg);
  assign next_addr = base_reg + ADDR_W'(cnt_inc);
  // An IO store may not start while the IO write FIFO is full
  assign io_block  = bus.mem_we && (bus.mem_addr[17:16] == IO_SEL) && io_buffer_full;
  // No grant in a cycle where a done pulse is visible: requester drops req first
  assign grant_ok  = !if_done_reg && !mem_done_reg;

  // Byte assembly: the lane selected by cnt takes ram_din, the rest keep buf_reg
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign cap_word[8*gi +: 8] = (cnt_reg[1:0] == 2'(gi)) ? ram_din : buf_reg[8*gi +: 8];
    end
  endgenerate

  // Next-state and datapath update for arbitration and byte sequencing
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    nbytes_next    = nbytes_reg;
    base_next      = base_reg;
    addr_next      = addr_reg;
    dout_next      = dout_reg;
    wr_next        = wr_reg;
    wdata_next     = wdata_reg;
    buf_next       = buf_reg;
    if_inst_next   = if_inst_reg;
    mem_rdata_next = mem_rdata_reg;
    if_done_next   = 1'b0;
    mem_done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_ok) begin
          if (bus.mem_req && !io_block) begin
            base_next   = bus.mem_addr;
            addr_next   = bus.mem_addr;
            cnt_next    = 3'd0;
            nbytes_next = len_bytes(bus.mem_len);
            buf_next    = '0;
            wdata_next  = bus.mem_wdata;
            if (bus.mem_we) begin
              state_next = ST_MEM_WR;
              dout_next  = bus.mem_wdata[7:0];
              wr_next    = 1'b1;
            end else begin
              state_next = ST_MEM_RD;
            end
          end else if (bus.if_req && !bus.if_abort) begin
            state_next  = ST_IF_RD;
            base_next   = bus.if_addr;
            addr_next   = bus.if_addr;
            cnt_next    = 3'd0;
            nbytes_next = 3'd4;
            buf_next    = '0;
          end
        end
      end
      ST_IF_RD, ST_MEM_RD: begin
        if (state_reg == ST_IF_RD && bus.if_abort) begin
          // redirect: drop partial bytes, no done pulse
          state_next = ST_IDLE;
          cnt_next   = 3'd0;
        end else if (last_byte) begin
          state_next = ST_IDLE;
          cnt_next   = 3'd0;
          buf_next   = cap_word;
          if (state_reg == ST_IF_RD) begin
            if_inst_next = cap_word;
            if_done_next = 1'b1;
          end else begin
            mem_rdata_next = cap_word;
            mem_done_next  = 1'b1;
          end
        end else begin
          buf_next  = cap_word;
          cnt_next  = cnt_inc;
          addr_next = next_addr;
        end
      end
      ST_MEM_WR: begin
        if (last_byte) begin
          wr_next       = 1'b0;
          mem_done_next = 1'b1;
          state_next    = ST_IDLE;
          cnt_next      = 3'd0;
        end else begin
          cnt_next  = cnt_inc;
          addr_next = next_addr;
          dout_next = get_byte(wdata_reg, cnt_inc[1:0]);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 3'd0;
      nbytes_reg    <= 3'd0;
      base_reg      <= '0;
      addr_reg      <= '0;
      dout_reg      <= 8'd0;
      wr_reg        <= 1'b0;
      wdata_reg     <= 32'd0;
      buf_reg       <= 32'd0;
      if_inst_reg   <= 32'd0;
      mem_rdata_reg <= 32'd0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
    end else if (rdy) begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      nbytes_reg    <= nbytes_next;
      base_reg      <= base_next;
      addr_reg      <= addr_next;
      dout_reg      <= dout_next;
      wr_reg        <= wr_next;
      wdata_reg     <= wdata_next;
      buf_reg       <= buf_next;
      if_inst_reg   <= if_inst_next;
      mem_rdata_reg <= mem_rdata_next;
      if_done_reg   <= if_done_next;
      mem_done_reg  <= mem_done_next;
    end
  end

  // A done held over a frozen cycle is only presented once rdy returns
  assign if_done_out   = if_done_reg & rdy;
  assign mem_done_out  = mem_done_reg & rdy;

  assign ram_a         = addr_reg;
  assign ram_dout      = dout_reg;
  assign ram_wr        = wr_reg & rdy;
  assign bus.if_done   = if_done_out;
  assign bus.mem_done  = mem_done_out;
  assign bus.if_inst   = if_inst_reg;
  assign bus.mem_rdata = mem_rdata_reg;
  assign bus.stall_req_if  = bus.if_req & ~if_done_out;
  assign bus.stall_req_mem = bus.mem_req & ~mem_done_out;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct {
    logic [31:0] data;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.IO_SEL(2'b11), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .io_buffer_full (io_buffer_full),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_a          (ram_a),
    .ram_wr         (ram_wr),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // RAM model: read data follows the address within the cycle
  logic [7:0] ram [0:262143];
  int         wr_count = 0;
  assign ram_din = ram[ram_a[17:0]];

  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_a[17:0]] = ram_dout;
      wr_count = wr_count + 1;
    end
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   if_done_cnt = 0;
  exp_t if_q[$];
  exp_t mem_q[$];
  logic [31:0] last_load = 32'd0;
  bit   prev_if_done = 1'b0;
  bit   prev_mem_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_if, input int limit, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < limit) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = is_if ? bus.if_done : bus.mem_done;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no pulse within %0d cycles, expected one", is_if ? "if_done" : "mem_done", limit);
    end
  endtask

  task automatic start_fetch(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    if_q.push_back('{exp, tag});
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
  endtask

  task automatic start_load(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] exp, input string tag);
    mem_q.push_back('{exp, tag});
    last_load     = exp;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_len   = len;
    bus.mem_addr  = addr;
    bus.mem_wdata = 32'd0;
  endtask

  // a store's done leaves mem_rdata at the last load value
  task automatic start_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data, input string tag);
    mem_q.push_back('{last_load, tag});
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_len   = len;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
  endtask

  task automatic check_zero(input string p);
    check({p, "_ram_wr"},    32'(ram_wr), 32'd0);
    check({p, "_ram_a"},     ram_a, 32'd0);
    check({p, "_ram_dout"},  32'(ram_dout), 32'd0);
    check({p, "_if_done"},   32'(bus.if_done), 32'd0);
    check({p, "_mem_done"},  32'(bus.mem_done), 32'd0);
    check({p, "_if_inst"},   bus.if_inst, 32'd0);
    check({p, "_mem_rdata"}, bus.mem_rdata, 32'd0);
  endtask

  // Monitor: compare every done pulse against the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.if_done && bus.mem_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL both_done: if_done=1 mem_done=1, expected at most one");
    end
    if (bus.if_done) begin
      if_done_cnt++;
      if (prev_if_done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL if_done_width: high 2 cycles, expected 1");
      end
      if (if_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_if_done: if_inst=0x%08h, expected no pulse", bus.if_inst);
      end else begin
        e = if_q.pop_front();
        $display("txn %s: if_inst=0x%08h expected=0x%08h", e.tag, bus.if_inst, e.data);
        check(e.tag, bus.if_inst, e.data);
      end
    end
    if (bus.mem_done) begin
      if (prev_mem_done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mem_done_width: high 2 cycles, expected 1");
      end
      if (mem_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_mem_done: mem_rdata=0x%08h, expected no pulse", bus.mem_rdata);
      end else begin
        e = mem_q.pop_front();
        $display("txn %s: mem_rdata=0x%08h expected=0x%08h", e.tag, bus.mem_rdata, e.data);
        check(e.tag, bus.mem_rdata, e.data);
      end
    end
    prev_if_done  = bus.if_done;
    prev_mem_done = bus.mem_done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ifc;
    int wc;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.if_abort  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_len   = 2'b00;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram['h100] = 8'h13; ram['h101] = 8'h05; ram['h102] = 8'h00; ram['h103] = 8'h00;
    ram['h180] = 8'hAA; ram['h181] = 8'hBB; ram['h182] = 8'hCC; ram['h183] = 8'hDD;
    ram['h200] = 8'h93; ram['h201] = 8'h00; ram['h202] = 8'h10; ram['h203] = 8'h00;
    ram['h400] = 8'h01; ram['h401] = 8'h02; ram['h402] = 8'h03; ram['h403] = 8'h04;
    ram['h0]   = 8'h5A; ram['h1]   = 8'h34; ram['h2]   = 8'h12; ram['h3FFFF] = 8'h78;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    check("reset_stall_if", 32'(bus.stall_req_if), 32'd0);
    step();
    rst = 1'b0;

    // 1: word fetch, address walk and 5-edge latency
    step();
    start_fetch(32'h100, 32'h00000513, "t1_fetch");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("t1_ram_a", ram_a, 32'h100 + k);
      if (k == 1) check("t1_stall_if_busy", 32'(bus.stall_req_if), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    check("t1_if_done_5th_edge", 32'(bus.if_done), 32'd1);
    check("t1_stall_if_done", 32'(bus.stall_req_if), 32'd0);
    step();
    bus.if_req = 1'b0;

    // 2: simultaneous requests, MEM wins; then IF; then lh readback
    step();
    start_store(32'h2002, LEN_HALF, 32'h0000BEEF, "t2_sh");
    start_fetch(32'h100, 32'h00000513, "t2_fetch");
    ifc = if_done_cnt;
    wait_done(1'b0, 10, lat);
    check("t2_sh_latency", lat, 32'd3);
    check("t2_if_not_first", if_done_cnt, ifc);
    step();
    bus.mem_req = 1'b0;
    wait_done(1'b1, 20, lat);
    check("t2_fetch_latency", lat, 32'd5);
    step();
    bus.if_req = 1'b0;
    check("t2_ram_2002", 32'(ram['h2002]), 32'hEF);
    check("t2_ram_2003", 32'(ram['h2003]), 32'hBE);
    check("t2_ram_2004", 32'(ram['h2004]), 32'h00);
    step();
    start_load(32'h2002, LEN_HALF, 32'h0000BEEF, "t2_lh");
    wait_done(1'b0, 10, lat);
    check("t2_lh_latency", lat, 32'd3);
    step();
    bus.mem_req = 1'b0;

    // 3: abort in the 3rd fetch cycle, redirected fetch @0x200
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h180;
    step();
    step();
    step();
    bus.if_abort = 1'b1;
    start_fetch(32'h200, 32'h00100093, "t3_refetch");
    step();
    bus.if_abort = 1'b0;
    wait_done(1'b1, 20, lat);
    check("t3_refetch_latency", lat, 32'd5);
    step();
    bus.if_req = 1'b0;

    // 4: IO store held off by io_buffer_full for 3 cycles
    step();
    io_buffer_full = 1'b1;
    wc = wr_count;
    start_store(32'h30000, LEN_BYTE, 32'h00000041, "t4_io_sb");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_ram_wr_blocked", 32'(ram_wr), 32'd0);
      @(posedge clk);
      #1;
    end
    io_buffer_full = 1'b0;
    wait_done(1'b0, 10, lat);
    check("t4_sb_latency", lat, 32'd2);
    step();
    bus.mem_req = 1'b0;
    check("t4_write_count", wr_count - wc, 32'd1);
    check("t4_ram_30000", 32'(ram['h30000]), 32'h41);

    // 5: lw reference, then same lw with rdy low for 2 cycles
    step();
    start_load(32'h400, LEN_WORD, 32'h04030201, "t5_lw_ref");
    wait_done(1'b0, 10, lat);
    check("t5_lw_latency", lat, 32'd5);
    step();
    bus.mem_req = 1'b0;
    step();
    start_load(32'h400, LEN_WORD, 32'h04030201, "t5_lw_stall");
    step();
    step();
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t5_frozen_ram_wr", 32'(ram_wr), 32'd0);
      check("t5_frozen_ram_a", ram_a, 32'h401);
      @(posedge clk);
      #1;
    end
    rdy = 1'b1;
    wait_done(1'b0, 10, lat);
    check("t5_resume_latency", lat, 32'd3);
    step();
    bus.mem_req = 1'b0;

    // 5b: sw with rdy low for one cycle: ram_wr gated, all 4 bytes land once
    step();
    wc = wr_count;
    start_store(32'h500, LEN_WORD, 32'hCAFEF00D, "t5_sw_stall");
    step();
    step();
    rdy = 1'b0;
    @(negedge clk);
    check("t5_wr_forced0", 32'(ram_wr), 32'd0);
    step();
    rdy = 1'b1;
    wait_done(1'b0, 10, lat);
    check("t5_sw_resume_latency", lat, 32'd3);
    step();
    bus.mem_req = 1'b0;
    check("t5_sw_write_count", wr_count - wc, 32'd4);
    check("t5_sw_word", {ram['h503], ram['h502], ram['h501], ram['h500]}, 32'hCAFEF00D);

    // 6: reset during a word store after byte 1
    step();
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_len   = LEN_WORD;
    bus.mem_addr  = 32'h600;
    bus.mem_wdata = 32'h11223344;
    step();
    step();
    rst = 1'b1;
    bus.mem_req = 1'b0;
    step();
    @(negedge clk);
    check_zero("t6_reset");
    step();
    rst = 1'b0;
    last_load = 32'd0;
    check("t6_ram_600", 32'(ram['h600]), 32'h44);
    check("t6_ram_601", 32'(ram['h601]), 32'h33);
    check("t6_ram_602", 32'(ram['h602]), 32'h00);
    step();
    start_load(32'h0, LEN_BYTE, 32'h0000005A, "t6_lb");
    wait_done(1'b0, 10, lat);
    check("t6_lb_latency", lat, 32'd2);
    step();
    bus.mem_req = 1'b0;

    // 7: address wrap from 0xFFFFFFFF
    step();
    start_load(32'hFFFFFFFF, LEN_WORD, 32'h12345A78, "t7_wrap_lw");
    @(posedge clk);
    @(negedge clk);
    check("t7_ram_a_base", ram_a, 32'hFFFFFFFF);
    @(posedge clk);
    @(negedge clk);
    check("t7_ram_a_wrap", ram_a, 32'h00000000);
    wait_done(1'b0, 10, lat);
    check("t7_rest_latency", lat, 32'd3);
    step();
    bus.mem_req = 1'b0;

    // 8: if_abort in IDLE delays the grant by one cycle
    step();
    start_fetch(32'h100, 32'h00000513, "t8_idle_abort");
    bus.if_abort = 1'b1;
    step();
    bus.if_abort = 1'b0;
    wait_done(1'b1, 20, lat);
    check("t8_latency_after_abort", lat, 32'd5);
    step();
    bus.if_req = 1'b0;

    repeat (3) step();
    check("if_q_drained", if_q.size(), 32'd0);
    check("mem_q_drained", mem_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
